// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op/state types, datapath width and op-class helpers
// for the RV64M multiply/divide unit.
package muldiv_unit_pkg;
   localparam int XLEN = 64;
   typedef enum logic [3:0] {
      MD_MUL   = 4'h0, MD_DIV   = 4'h1, MD_DIVU  = 4'h2, MD_REM  = 4'h3, MD_REMU  = 4'h4,
      MD_MULW  = 4'h8, MD_DIVW  = 4'h9, MD_DIVUW = 4'hA, MD_REMW = 4'hB, MD_REMUW = 4'hC
   } md_op_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
   function automatic logic is_word_op(input md_op_t op);
      return op[3];
   endfunction
   function automatic logic is_signed_op(input md_op_t op);
      return op[2:0] == 3'd1 || op[2:0] == 3'd3;
   endfunction
   function automatic logic is_mul_op(input md_op_t op);
      return op[2:0] == 3'd0;
   endfunction
   function automatic logic is_rem_op(input md_op_t op);
      return op[2:0] == 3'd3 || op[2:0] == 3'd4;
   endfunction
endpackage

// File: rtl/muldiv_unit_div_core.sv
// muldiv_unit_div_core: restoring divider on operand magnitudes, one quotient bit
// per cycle; its iteration counter also paces the shift-add multiplier.
module muldiv_unit_div_core import muldiv_unit_pkg::*; #(
   parameter int W     = 64,
   parameter int CNT_W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_start,
   input  logic         i_step,
   input  logic         i_word,
   input  logic [W-1:0] i_dividend,
   input  logic [W-1:0] i_divisor,
   output logic [W-1:0] o_quot_nxt,
   output logic [W-1:0] o_rem_nxt,
   output logic         o_last
);
   logic [W-1:0]     r_rem, r_quot, r_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_word;
   logic [W:0]       w_sh;
   logic             w_ge;
   assign w_sh       = {r_rem, r_quot[W-1]};
   assign w_ge       = w_sh >= {1'b0, r_div};
   assign o_rem_nxt  = w_ge ? w_sh[W-1:0] - r_div : w_sh[W-1:0];
   assign o_quot_nxt = {r_quot[W-2:0], w_ge};
   assign o_last     = r_cnt == (r_word ? CNT_W'(31) : CNT_W'(W-1));
   // word dividends sit in the upper half so 32 shifts bring every bit through
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem  <= '0;
         r_quot <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
         r_word <= 1'b0;
      end else if (i_start) begin
         r_rem  <= '0;
         r_quot <= i_word ? {i_dividend[W-33:0], 32'b0} : i_dividend;
         r_div  <= i_divisor;
         r_cnt  <= '0;
         r_word <= i_word;
      end else if (i_step) begin
         r_rem  <= o_rem_nxt;
         r_quot <= o_quot_nxt;
         r_cnt  <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide with exe_wait stall handshake.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (divides unchanged).
module muldiv_unit import muldiv_unit_pkg::*; #(
   parameter int XLEN  = muldiv_unit_pkg::XLEN,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid,
   input  md_op_t          op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            hold,
   input  logic            kill,
   output logic            exe_wait,
   output logic [XLEN-1:0] result,
   output logic            done
);
   function automatic logic [XLEN-1:0] sx(input logic w, input logic [XLEN-1:0] v);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction
   md_state_t       r_state, w_state_nxt;
   logic            w_word, w_sgn, w_mul, w_rem, w_neg_a, w_neg_b, w_special, w_direct;
   logic            w_accept, w_step, w_last;
   logic [XLEN-1:0] w_a_x, w_b_x, w_mag_a, w_mag_b, w_min, w_spec_res, w_direct_res;
   logic [XLEN-1:0] w_quot_nxt, w_rem_nxt, w_acc_nxt, w_fin;
   logic            r_word, r_mul, r_rem, r_neg_q, r_neg_r;
   logic [XLEN-1:0] r_acc, r_mcand, r_mplier, r_result;
   assign w_word     = is_word_op(op);
   assign w_sgn      = is_signed_op(op);
   assign w_mul      = is_mul_op(op);
   assign w_rem      = is_rem_op(op);
   assign w_a_x      = (w_word & !w_sgn) ? {{(XLEN-32){1'b0}}, a[31:0]} : sx(w_word, a);
   assign w_b_x      = (w_word & !w_sgn) ? {{(XLEN-32){1'b0}}, b[31:0]} : sx(w_word, b);
   assign w_neg_a    = w_sgn & w_a_x[XLEN-1];
   assign w_neg_b    = w_sgn & w_b_x[XLEN-1];
   assign w_mag_a    = w_neg_a ? -w_a_x : w_a_x;
   assign w_mag_b    = w_neg_b ? -w_b_x : w_b_x;
   assign w_min      = w_word ? ~XLEN'(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};
   assign w_special  = !w_mul & ((w_b_x == '0) | (w_sgn & (w_a_x == w_min) & (w_b_x == '1)));
   assign w_spec_res = (w_b_x == '0) ? (w_rem ? w_a_x : '1) : (w_rem ? '0 : w_min);
`ifdef MULDIV_FAST_MUL_EN
   assign w_direct     = w_special | w_mul;
   assign w_direct_res = w_mul ? a * b : w_spec_res;
`else
   assign w_direct     = w_special;
   assign w_direct_res = w_spec_res;
`endif
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      if (kill) w_state_nxt = IDLE;
      else case (r_state)
         IDLE: begin
            w_accept    = valid;
            w_state_nxt = valid ? (w_direct ? DONE : BUSY) : IDLE;
         end
         BUSY: begin
            w_step      = 1'b1;
            w_state_nxt = w_last ? DONE : BUSY;
         end
         DONE:    w_state_nxt = hold ? DONE : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end
   assign exe_wait  = valid & !kill & (r_state != DONE);
   assign done      = (r_state == DONE) & !kill;
   assign result    = r_result;
   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_fin     = r_mul ? w_acc_nxt :
                      r_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt) :
                              (r_neg_q ? -w_quot_nxt : w_quot_nxt);
   muldiv_unit_div_core #(.W(XLEN), .CNT_W(CNT_W)) u_div (
      .clk        (clk),
      .rst        (reset),
      .i_start    (w_accept),
      .i_step     (w_step),
      .i_word     (w_word),
      .i_dividend (w_mag_a),
      .i_divisor  (w_mag_b),
      .o_quot_nxt (w_quot_nxt),
      .o_rem_nxt  (w_rem_nxt),
      .o_last     (w_last)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_result <= '0;
         r_word   <= 1'b0;
         r_mul    <= 1'b0;
         r_rem    <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_word   <= w_word;
            r_mul    <= w_mul;
            r_rem    <= w_rem;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            if (w_direct) r_result <= sx(w_word, w_direct_res);
         end
         if (w_step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) r_result <= sx(r_word, w_fin);
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an
// arithmetic reference model of RV64M results and op latencies.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;
   logic        clk = 1'b0;
   logic        reset, valid, hold, kill;
   md_op_t      op;
   logic [63:0] a, b, result, last_res;
   logic        exe_wait, done;
   int          n_cmp = 0, n_err = 0;
   md_op_t      ops [10] = '{MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU,
                             MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};

   muldiv_unit dut (
      .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b),
      .hold(hold), .kill(kill), .exe_wait(exe_wait), .result(result), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] model(input md_op_t o, input logic [63:0] x, input logic [63:0] y);
      longint      sx64, sy64, q64;
      int          sx32, sy32, q32;
      logic [31:0] ux, uy, w;
      logic [63:0] r;
      sx64 = x; sy64 = y; sx32 = x[31:0]; sy32 = y[31:0]; ux = x[31:0]; uy = y[31:0];
      w = '0; r = '0;
      case (o)
         MD_MUL:  r = x * y;
         MD_DIVU: r = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : x / y;
         MD_REMU: r = (y == 0) ? x : x % y;
         MD_DIV: begin
            if (y == 0) r = '1;
            else if (x == 64'h8000_0000_0000_0000 && y == '1) r = x;
            else begin q64 = sx64 / sy64; r = q64; end
         end
         MD_REM: begin
            if (y == 0) r = x;
            else if (x == 64'h8000_0000_0000_0000 && y == '1) r = 0;
            else begin q64 = sx64 % sy64; r = q64; end
         end
         MD_MULW:  w = ux * uy;
         MD_DIVUW: w = (uy == 0) ? 32'hFFFF_FFFF : ux / uy;
         MD_REMUW: w = (uy == 0) ? ux : ux % uy;
         MD_DIVW: begin
            if (uy == 0) w = '1;
            else if (ux == 32'h8000_0000 && uy == '1) w = ux;
            else begin q32 = sx32 / sy32; w = q32; end
         end
         MD_REMW: begin
            if (uy == 0) w = ux;
            else if (ux == 32'h8000_0000 && uy == '1) w = 0;
            else begin q32 = sx32 % sy32; w = q32; end
         end
         default: r = 'x;
      endcase
      return o[3] ? {{32{w[31]}}, w} : r;
   endfunction

   function automatic int exp_lat(input md_op_t o, input logic [63:0] x, input logic [63:0] y);
      bit wd, sg, mul, zero, ovf;
      wd   = (o == MD_MULW || o == MD_DIVW || o == MD_DIVUW || o == MD_REMW || o == MD_REMUW);
      sg   = (o == MD_DIV || o == MD_REM || o == MD_DIVW || o == MD_REMW);
      mul  = (o == MD_MUL || o == MD_MULW);
      zero = wd ? (y[31:0] == 0) : (y == 0);
      ovf  = sg && (wd ? (x[31:0] == 32'h8000_0000 && y[31:0] == '1)
                       : (x == 64'h8000_0000_0000_0000 && y == '1));
`ifdef MULDIV_FAST_MUL_EN
      if (mul) return 1;
`endif
      if (!mul && (zero || ovf)) return 1;
      return wd ? 33 : 65;
   endfunction

   // caller is at posedge+2; op is offered with valid held until done
   task automatic run_op(input md_op_t o, input logic [63:0] x, input logic [63:0] y, input int nhold);
      logic [63:0] er;
      int          el, cyc, ew_bad;
      er = model(o, x, y);
      el = exp_lat(o, x, y);
      op = o; a = x; b = y; valid = 1'b1; ew_bad = 0;
      for (cyc = 0; cyc < 200; cyc++) begin
         #1;
         if (done) break;
         if (exe_wait !== 1'b1) ew_bad++;
         @(posedge clk); #1;
         a = rnd64(); b = rnd64();
      end
      chk("done_seen", 64'(done), 64'd1);
      chk("latency", 64'(cyc), 64'(el));
      chk("result", result, er);
      chk("exe_wait_pending", 64'(ew_bad), 64'd0);
      chk("exe_wait_done", 64'(exe_wait), 64'd0);
      if (nhold > 0) begin
         hold = 1'b1;
         repeat (nhold) begin
            @(posedge clk); #2;
            chk("hold_done", 64'(done), 64'd1);
            chk("hold_result", result, er);
            chk("hold_exe_wait", 64'(exe_wait), 64'd0);
         end
         hold = 1'b0;
      end
      valid = 1'b0;
      @(posedge clk); #2;
      chk("idle_after_done", 64'(done), 64'd0);
      last_res = er;
   endtask

   initial begin
      int       mode, seen;
      md_op_t   o;
      logic [63:0] x, y;
      reset = 1'b1; valid = 1'b0; hold = 1'b0; kill = 1'b0;
      op = MD_MUL; a = '0; b = '0; last_res = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_result", result, 64'd0);
      chk("reset_exe_wait", 64'(exe_wait), 64'd0);
      reset = 1'b0;
      @(posedge clk); #2;

      run_op(MD_DIVU, 64'd100, 64'd7, 0);
      run_op(MD_DIV, -64'sd7, 64'd2, 0);
      run_op(MD_REM, -64'sd7, 64'd2, 0);
      run_op(MD_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 0);
      run_op(MD_DIVU, 64'd12345, 64'd0, 0);
      run_op(MD_MULW, 64'h7FFF_FFFF, 64'd2, 0);
      run_op(MD_REMUW, 64'hDEAD_BEEF_8765_4321, 64'hFFFF_FFFF_0000_0000, 0);
      run_op(MD_DIV, 64'h8000_0000_0000_0000, '1, 0);
      run_op(MD_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 3);
      run_op(MD_REMW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 2);

      // kill during BUSY aborts with no result and no done
      op = MD_DIVU; a = rnd64(); b = 64'd3; valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      kill = 1'b1;
      #1;
      chk("kill_exe_wait", 64'(exe_wait), 64'd0);
      @(posedge clk); #1;
      kill = 1'b0; valid = 1'b0;
      #1;
      chk("kill_idle", 64'(done), 64'd0);
      seen = 0;
      repeat (80) begin
         @(posedge clk); #2;
         if (done) seen = 1;
      end
      chk("kill_never_done", 64'(seen), 64'd0);
      chk("kill_result_kept", result, last_res);

      // asynchronous reset mid-op
      op = MD_DIV; a = rnd64() >> 1; b = 64'd7; valid = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midop_reset_done", 64'(done), 64'd0);
      chk("midop_reset_result", result, 64'd0);
      chk("midop_reset_exe_wait", 64'(exe_wait), 64'd1);
      valid = 1'b0;
      #1;
      reset = 1'b0;
      @(posedge clk); #2;
      chk("post_reset_idle", 64'(done), 64'd0);
      last_res = '0;

      for (int i = 0; i < 50; i++) begin
         o    = ops[$urandom_range(0, 9)];
         mode = $urandom_range(0, 5);
         x = rnd64(); y = rnd64();
         case (mode)
            1: begin x = 64'($urandom_range(0, 5000)) - 64'd2500; y = 64'($urandom_range(1, 40)) - 64'd20; end
            2: y = {rnd64() & 64'hFFFF_FFFF_0000_0000};
            3: begin x = 64'h8000_0000_0000_0000; y = '1; end
            4: begin x = {$urandom, 32'h8000_0000}; y = {$urandom, 32'hFFFF_FFFF}; end
            5: y = y >> $urandom_range(20, 62);
            default: ;
         endcase
         run_op(o, x, y, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
